// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 matrix keypad one column at a time, debounces
// presses and releases, and emits the accepted key position with a one-cycle
// write strobe for the downstream register bank.
// Optional feature: define KEYPAD_REPEAT_EN to emit auto-repeat strobes while
// a key stays held (first after REPEAT_DLY samples, then every REPEAT_PER).
module keypad_scanner #(
    parameter int SCAN_DIV     = 5000,
    parameter int DEBOUNCE_CNT = 4,
    parameter int REPEAT_DLY   = 200,
    parameter int REPEAT_PER   = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] fila,
    output logic [3:0] col,
    output logic [3:0] posicion,
    output logic       opr
);
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CNT);

    typedef enum logic [1:0] {
        ST_SCAN      = 2'd0,
        ST_DEB_PRESS = 2'd1,
        ST_PRESSED   = 2'd2,
        ST_DEB_REL   = 2'd3
    } state_t;

    logic [3:0]       sync_r;
    logic [3:0]       fs_r;
    logic [DIV_W-1:0] div_r;
    logic             sample_s;
    logic             pressed_s;
    logic [3:0]       code_s;
    logic [3:0]       col_rot_s;
    state_t           state_r;
    state_t           state_nxt_s;
    logic [3:0]       col_r;
    logic [3:0]       col_nxt_s;
    logic [3:0]       cand_r;
    logic [3:0]       cand_nxt_s;
    logic [3:0]       pos_r;
    logic [3:0]       pos_nxt_s;
    logic             opr_r;
    logic             opr_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [CNT_W-1:0] cnt_inc_s;

`ifdef KEYPAD_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0] rpt_cnt_r;
    logic [RPT_W-1:0] rpt_cnt_nxt_s;
    logic [RPT_W-1:0] rpt_inc_s;
    logic             rpt_first_r;
    logic             rpt_first_nxt_s;

    assign rpt_inc_s = rpt_cnt_r + RPT_W'(1);
`endif

    // Lowest-index active-low row wins.
    function automatic logic [1:0] row_index(input logic [3:0] rows);
        logic [1:0] idx;
        casez (rows)
            4'b???0: idx = 2'd0;
            4'b??01: idx = 2'd1;
            4'b?011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Index of the column currently driven low.
    function automatic logic [1:0] col_index(input logic [3:0] cols);
        logic [1:0] idx;
        case (cols)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    assign sample_s  = (div_r == DIV_LAST);
    assign pressed_s = (fs_r != 4'b1111);
    assign code_s    = {row_index(fs_r), col_index(col_r)};
    assign col_rot_s = {col_r[2:0], col_r[3]};
    assign cnt_inc_s = (cnt_r == CNT_DONE) ? cnt_r : (cnt_r + CNT_W'(1));

    assign col      = col_r;
    assign posicion = pos_r;
    assign opr      = opr_r;

    // Row synchronizer and dwell/sample divider.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= 4'b1111;
            fs_r   <= 4'b1111;
            div_r  <= '0;
        end else begin
            sync_r <= fila;
            fs_r   <= sync_r;
            div_r  <= sample_s ? '0 : (div_r + DIV_W'(1));
        end
    end

    // Next-state and datapath decisions, evaluated once per sample.
    always_comb begin
        state_nxt_s = state_r;
        col_nxt_s   = col_r;
        cand_nxt_s  = cand_r;
        pos_nxt_s   = pos_r;
        opr_nxt_s   = 1'b0;
        cnt_nxt_s   = cnt_r;
`ifdef KEYPAD_REPEAT_EN
        rpt_cnt_nxt_s   = rpt_cnt_r;
        rpt_first_nxt_s = rpt_first_r;
`endif
        if (sample_s) begin
            case (state_r)
                ST_SCAN: begin
                    if (pressed_s) begin
                        cand_nxt_s = code_s;
                        cnt_nxt_s  = CNT_W'(1);
                        if (DEBOUNCE_CNT == 1) begin
                            state_nxt_s = ST_PRESSED;
                            opr_nxt_s   = 1'b1;
                            pos_nxt_s   = code_s;
`ifdef KEYPAD_REPEAT_EN
                            rpt_cnt_nxt_s   = '0;
                            rpt_first_nxt_s = 1'b0;
`endif
                        end else begin
                            state_nxt_s = ST_DEB_PRESS;
                        end
                    end else begin
                        col_nxt_s = col_rot_s;
                    end
                end
                ST_DEB_PRESS: begin
                    if (pressed_s && (code_s == cand_r)) begin
                        cnt_nxt_s = cnt_inc_s;
                        if (cnt_inc_s == CNT_DONE) begin
                            state_nxt_s = ST_PRESSED;
                            opr_nxt_s   = 1'b1;
                            pos_nxt_s   = cand_r;
`ifdef KEYPAD_REPEAT_EN
                            rpt_cnt_nxt_s   = '0;
                            rpt_first_nxt_s = 1'b0;
`endif
                        end else begin
                            state_nxt_s = ST_DEB_PRESS;
                        end
                    end else begin
                        // Column stays frozen so scanning resumes right here.
                        state_nxt_s = ST_SCAN;
                    end
                end
                ST_PRESSED: begin
                    if (pressed_s) begin
                        state_nxt_s = ST_PRESSED;
`ifdef KEYPAD_REPEAT_EN
                        if ((!rpt_first_r && (rpt_inc_s == RPT_W'(REPEAT_DLY))) ||
                            ( rpt_first_r && (rpt_inc_s == RPT_W'(REPEAT_PER)))) begin
                            opr_nxt_s       = 1'b1;
                            rpt_cnt_nxt_s   = '0;
                            rpt_first_nxt_s = 1'b1;
                        end else begin
                            rpt_cnt_nxt_s = rpt_inc_s;
                        end
`endif
                    end else begin
`ifdef KEYPAD_REPEAT_EN
                        rpt_cnt_nxt_s   = '0;
                        rpt_first_nxt_s = 1'b0;
`endif
                        if (DEBOUNCE_CNT == 1) begin
                            state_nxt_s = ST_SCAN;
                            col_nxt_s   = col_rot_s;
                        end else begin
                            state_nxt_s = ST_DEB_REL;
                            cnt_nxt_s   = CNT_W'(1);
                        end
                    end
                end
                ST_DEB_REL: begin
                    if (!pressed_s) begin
                        cnt_nxt_s = cnt_inc_s;
                        if (cnt_inc_s == CNT_DONE) begin
                            state_nxt_s = ST_SCAN;
                            col_nxt_s   = col_rot_s;
                        end else begin
                            state_nxt_s = ST_DEB_REL;
                        end
                    end else begin
                        // Release bounce: back to held, no new strobe.
                        state_nxt_s = ST_PRESSED;
`ifdef KEYPAD_REPEAT_EN
                        rpt_cnt_nxt_s   = '0;
                        rpt_first_nxt_s = 1'b0;
`endif
                    end
                end
                default: begin
                    state_nxt_s = ST_SCAN;
                    col_nxt_s   = 4'b1110;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_SCAN;
            col_r   <= 4'b1110;
            cand_r  <= 4'h0;
            pos_r   <= 4'h0;
            opr_r   <= 1'b0;
            cnt_r   <= '0;
`ifdef KEYPAD_REPEAT_EN
            rpt_cnt_r   <= '0;
            rpt_first_r <= 1'b0;
`endif
        end else begin
            state_r <= state_nxt_s;
            col_r   <= col_nxt_s;
            cand_r  <= cand_nxt_s;
            pos_r   <= pos_nxt_s;
            opr_r   <= opr_nxt_s;
            cnt_r   <= cnt_nxt_s;
`ifdef KEYPAD_REPEAT_EN
            rpt_cnt_r   <= rpt_cnt_nxt_s;
            rpt_first_r <= rpt_first_nxt_s;
`endif
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: drives a modelled 4x4 key matrix, predicts strobes with a
// sample-level reference model and checks them through a scoreboard queue.
`timescale 1ns/1ps
module tb_keypad_scanner;
    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;
    localparam int RDLY     = 5;
    localparam int RPER     = 2;

    typedef struct {
        logic [3:0] pos;
        int         smp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  fila;
    logic [3:0]  col;
    logic [3:0]  posicion;
    logic        opr;
    logic [15:0] keys = 16'h0000;   // bit r*4+c: key at row r, column c held
    logic [3:0]  last_pos = 4'h0;

    int   checks = 0;
    int   errors = 0;
    int   sample_idx = 0;
    exp_t exp_q[$];

    // Reference model state, in sample units.
    int m_col, m_run, m_quiet, m_rep;
    bit m_held, m_rep_first;
    logic [3:0] m_cand;

    keypad_scanner #(
        .SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEB),
        .REPEAT_DLY(RDLY), .REPEAT_PER(RPER)
    ) dut (
        .clk(clk), .rst(rst), .fila(fila),
        .col(col), .posicion(posicion), .opr(opr)
    );

    always #5 clk = ~clk;

    // Board: a held key pulls its row low when its column is driven low.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            fila[r] = 1'b1;
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && (col[c] === 1'b0)) fila[r] = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (sample %0d)", name, act, exp, sample_idx);
        end
    endtask

    task automatic model_reset();
        m_col = 0; m_run = 0; m_quiet = 0; m_rep = 0;
        m_held = 0; m_rep_first = 0; m_cand = 4'h0;
    endtask

    task automatic predict(input logic [3:0] p);
        exp_t e;
        e.pos = p;
        e.smp = sample_idx;
        exp_q.push_back(e);
    endtask

    // One sample as seen by the scanner: which key (if any) shows on the current column.
    task automatic model_sample();
        int row;
        logic [3:0] code;
        row = -1;
        for (int r = 3; r >= 0; r--) if (keys[r*4+m_col]) row = r;
        code = 4'((row < 0 ? 0 : row) * 4 + m_col);
        if (m_held) begin
            if (row < 0) begin
                m_quiet++;
                m_rep = 0; m_rep_first = 0;
                if (m_quiet >= DEB) begin
                    m_held = 0; m_quiet = 0; m_col = (m_col + 1) % 4;
                end
            end else if (m_quiet > 0) begin
                m_quiet = 0; m_rep = 0; m_rep_first = 0;
            end else begin
`ifdef KEYPAD_REPEAT_EN
                m_rep++;
                if (m_rep == (m_rep_first ? RPER : RDLY)) begin
                    predict(m_cand); m_rep = 0; m_rep_first = 1;
                end
`endif
            end
        end else if (m_run > 0) begin
            if (row >= 0 && code == m_cand) begin
                m_run++;
                if (m_run >= DEB) begin
                    m_held = 1; m_run = 0; m_quiet = 0; m_rep = 0; m_rep_first = 0;
                    predict(m_cand);
                end
            end else begin
                m_run = 0;
            end
        end else if (row >= 0) begin
            m_cand = code; m_run = 1;
            if (DEB == 1) begin
                m_held = 1; m_run = 0; predict(m_cand);
            end
        end else begin
            m_col = (m_col + 1) % 4;
        end
    endtask

    // Advance to the next sample edge, update the model, check the column drive.
    task automatic step();
        logic [3:0] exp_col;
        repeat (SCAN_DIV) @(posedge clk);
        #1;
        sample_idx++;
        model_sample();
        exp_col = 4'b1111 ^ (4'b0001 << m_col);
        chk("col", col, exp_col);
    endtask

    task automatic hold(input logic [15:0] k, input int n);
        keys = k;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        chk("reset_col", col, 4'b1110);
        chk("reset_pos", posicion, 4'h0);
        chk("reset_opr", {3'b000, opr}, 4'h0);
    endtask

    // Scoreboard monitor: each strobe must match the oldest prediction in value and sample.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                last_pos = 4'h0;
            end else if (opr === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL strobe_unexpected: got opr=1 posicion=%h at sample %0d, expected none",
                             posicion, sample_idx);
                end else begin
                    e = exp_q.pop_front();
                    if (posicion !== e.pos || sample_idx != e.smp) begin
                        errors++;
                        $display("FAIL strobe: got posicion=%h at sample %0d expected %h at sample %0d",
                                 posicion, sample_idx, e.pos, e.smp);
                    end
                    last_pos = e.pos;
                end
            end else begin
                checks++;
                if (posicion !== last_pos || opr !== 1'b0) begin
                    errors++;
                    $display("FAIL pos_hold: got posicion=%h opr=%b expected %h opr=0",
                             posicion, opr, last_pos);
                end
            end
        end
    end

    // Stimulus: directed scenarios, then randomized key activity.
    initial begin
        int kind, dur, a, b;
        model_reset();
        do_reset(3);
        hold(16'h0000, 6);                          // idle column rotation
        hold(16'h0001 << 10, 20);                   // row 2, column 2 -> 4'hA
        hold(16'h0000, 8);
        for (int i = 0; i < 4 && m_col != 0; i++) step();
        hold(16'h0001 << 4, 2);                     // row 1 col 0 bounce
        hold(16'h0000, 6);
        keys = 16'h0001 << 5;                       // key 4'h5, reset mid-debounce
        for (int i = 0; i < 8 && !(m_run > 0); i++) step();
        do_reset(1);
        hold(16'h0001 << 5, 20);                    // fresh acceptance after reset
        hold(16'h0000, 8);
        hold((16'h0001 << 7) | (16'h0001 << 15), 16); // rows 1 and 3 in col 3 -> 4'h7
        hold(16'h0000, 8);
        hold(16'h0001, 16);                         // row 0 col 0 -> 4'h0
        hold(16'h0000, 8);
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 3);
            dur  = $urandom_range(1, 20);
            a    = $urandom_range(0, 15);
            b    = $urandom_range(0, 15);
            case (kind)
                0:       hold(16'h0000, dur);
                1:       hold(16'h0001 << a, dur);
                2:       hold((16'h0001 << a) | (16'h0001 << b), dur);
                default: hold(16'h0001 << a, $urandom_range(1, 2));
            endcase
        end
        hold(16'h0000, 10);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_strobes: got %0d outstanding expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
